output_writer: RTL and testbench

// - Return path of the routing fabric: collects per-row PE results and writes them to the output SRAM write port.
// - Up to ROUTER_COUNT lanes per beat; valid lanes are compacted in lane order.
// - Elements are packed into SRAM_DATA_WIDTH words and written to consecutive addresses from i_start_addr.
// - Sits between the PE array drain and the output sram instance; the top-level controller starts it and waits on o_done.

---
 rtl/output_writer.sv | 200 ++++++++++++++++++++
 tb/tb_output_writer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_writer.sv
// output_writer: compacts valid PE lanes in lane order, packs them into SRAM words at consecutive addresses.
// Latency: a word completed by an accepted beat is written 1 cycle later; the residual partial word is written from FLUSH.
// Backpressure: o_ready is high only in RUN and never stalls there; build option OUTPUT_WRITER_RELU_EN clamps negative elements to 0.
module output_writer #(
  parameter int SRAM_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH      = 8,
  parameter int ROUTER_COUNT    = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                                 i_clk,
  input  logic                                 i_nrst,
  input  logic                                 i_en,
  input  logic                                 i_reg_clear,
  input  logic [ADDR_WIDTH-1:0]                i_start_addr,
  input  logic [COUNT_WIDTH-1:0]               i_out_count,
  input  logic [ROUTER_COUNT*DATA_WIDTH-1:0]   i_data,
  input  logic [ROUTER_COUNT-1:0]              i_data_valid,
  output logic                                 o_ready,
  output logic                                 o_sram_write_en,
  output logic [ADDR_WIDTH-1:0]                o_sram_write_addr,
  output logic [SRAM_DATA_WIDTH-1:0]           o_sram_data,
  output logic                                 o_done,
  output logic                                 o_overflow
);

  // Elements per SRAM word, and pack-buffer depth: a residual of at most
  // EPW-1 elements plus one full beat of ROUTER_COUNT lanes.
  localparam int EPW    = SRAM_DATA_WIDTH / DATA_WIDTH;
  localparam int BUF    = EPW + ROUTER_COUNT - 1;
  localparam int FILL_W = $clog2(BUF + 1);
  localparam logic [FILL_W-1:0] EPW_F = FILL_W'(EPW);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef logic [BUF-1:0][DATA_WIDTH-1:0] pack_t;

  logic [1:0]                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [COUNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0]     elem_q, elem_d;
  logic [FILL_W-1:0]          fill_q, fill_d;
  pack_t                      buf_q, buf_d;
  logic                       ovf_q, ovf_d;
  logic                       wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]      wr_addr_q, wr_addr_d;
  logic [SRAM_DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  // Beat-level helpers
  pack_t                      app;
  logic [FILL_W-1:0]          take;
  logic                       drop;
  logic [COUNT_WIDTH-1:0]     rem;
  logic [COUNT_WIDTH-1:0]     elem_after;
  logic [FILL_W-1:0]          fill_after;
  logic                       beat;
  logic [SRAM_DATA_WIDTH-1:0] resid_word;

  // Element shaping applied on acceptance; zero added latency either way.
  function automatic logic [DATA_WIDTH-1:0] shape(input logic [DATA_WIDTH-1:0] v);
`ifdef OUTPUT_WRITER_RELU_EN
    shape = v[DATA_WIDTH-1] ? '0 : v;
`else
    shape = v;
`endif
  endfunction

  assign beat       = (state_q == S_RUN) && (|i_data_valid);
  assign rem        = cnt_q - elem_q;
  assign elem_after = elem_q + COUNT_WIDTH'(take);
  assign fill_after = fill_q + take;

  // Compact valid lanes (lowest first) onto the buffer tail; lanes beyond the remaining count are dropped.
  always_comb begin
    app  = buf_q;
    take = '0;
    drop = 1'b0;
    for (int r = 0; r < ROUTER_COUNT; r++) begin
      if (i_data_valid[r]) begin
        if (COUNT_WIDTH'(take) < rem) begin
          app[fill_q + take] = shape(i_data[r*DATA_WIDTH +: DATA_WIDTH]);
          take = take + FILL_W'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  // Residual word for FLUSH: live elements only, upper slots forced to zero.
  always_comb begin
    resid_word = '0;
    for (int k = 0; k < EPW; k++) begin
      if (FILL_W'(k) < fill_q) begin
        resid_word[k*DATA_WIDTH +: DATA_WIDTH] = buf_q[k];
      end
    end
  end

  // Next-state logic: job start, beat packing, word emission, flush and completion.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    elem_d    = elem_q;
    fill_d    = fill_q;
    buf_d     = buf_q;
    ovf_d     = ovf_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_en) begin
          addr_d  = i_start_addr;
          cnt_d   = i_out_count;
          elem_d  = '0;
          fill_d  = '0;
          buf_d   = '0;
          ovf_d   = 1'b0;
          state_d = (i_out_count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (beat) begin
          elem_d = elem_after;
          if (drop) begin
            ovf_d = 1'b1;
          end
          if (fill_after >= EPW_F) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = app[EPW-1:0];
            addr_d    = addr_q + ADDR_WIDTH'(1);
            buf_d     = app >> (EPW * DATA_WIDTH);
            fill_d    = fill_after - EPW_F;
          end else begin
            buf_d  = app;
            fill_d = fill_after;
          end
          if (elem_after == cnt_q) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (fill_q != '0) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = resid_word;
          addr_d    = addr_q + ADDR_WIDTH'(1);
          fill_d    = '0;
          buf_d     = '0;
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset and register clear both return everything to IDLE with zeroed outputs.
  always_ff @(posedge i_clk) begin
    if (!i_nrst || i_reg_clear) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      elem_q    <= '0;
      fill_q    <= '0;
      buf_q     <= '0;
      ovf_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      elem_q    <= elem_d;
      fill_q    <= fill_d;
      buf_q     <= buf_d;
      ovf_q     <= ovf_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // o_done is held off while the final residual write pulse is still on the port,
  // so completion is only signalled once every word has been written.
  assign o_ready           = (state_q == S_RUN);
  assign o_done            = (state_q == S_DONE) && !wr_en_q;
  assign o_sram_write_en   = wr_en_q;
  assign o_sram_write_addr = wr_addr_q;
  assign o_sram_data       = wr_data_q;
  assign o_overflow        = ovf_q;

endmodule

// File: tb/tb_output_writer.sv
// Bench for output_writer: directed timing sequences, a vector table of whole jobs,
// and randomized jobs checked against an element-stream reference model.
module tb_output_writer;

  logic        i_clk;
  logic        i_nrst;
  logic        i_en;
  logic        i_reg_clear;
  logic [7:0]  i_start_addr;
  logic [15:0] i_out_count;
  logic [31:0] i_data;
  logic [3:0]  i_data_valid;
  logic        o_ready;
  logic        o_sram_write_en;
  logic [7:0]  o_sram_write_addr;
  logic [63:0] o_sram_data;
  logic        o_done;
  logic        o_overflow;

  output_writer dut (
    .i_clk             (i_clk),
    .i_nrst            (i_nrst),
    .i_en              (i_en),
    .i_reg_clear       (i_reg_clear),
    .i_start_addr      (i_start_addr),
    .i_out_count       (i_out_count),
    .i_data            (i_data),
    .i_data_valid      (i_data_valid),
    .o_ready           (o_ready),
    .o_sram_write_en   (o_sram_write_en),
    .o_sram_write_addr (o_sram_write_addr),
    .o_sram_data       (o_sram_data),
    .o_done            (o_done),
    .o_overflow        (o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  obs_addr[$];
  logic [63:0] obs_data[$];
  logic [3:0]  beat_m[$];
  logic [31:0] beat_d[$];
  logic [7:0]  acc[$];
  bit          dropped;

  typedef struct packed {
    logic [7:0]        start;
    logic [15:0]       count;
    logic [2:0]        nbeats;
    logic [3:0][3:0]   mask;
    logic [3:0][31:0]  data;
    logic [1:0]        nwr;
    logic [1:0][7:0]   waddr;
    logic [1:0][63:0]  wdata;
    logic              ovf;
  } vec_t;

  vec_t tbl[8];

  function automatic vec_t mk(input logic [7:0] s, input logic [15:0] c, input int nb,
                              input logic [15:0] m, input logic [127:0] d, input int nw,
                              input logic [15:0] a, input logic [127:0] w, input logic o);
    vec_t v;
    v.start = s; v.count = c; v.nbeats = 3'(nb); v.mask = m; v.data = d;
    v.nwr = 2'(nw); v.waddr = a; v.wdata = w; v.ovf = o;
    return v;
  endfunction

  function automatic logic [7:0] relu8(input logic [7:0] x);
`ifdef OUTPUT_WRITER_RELU_EN
    return x[7] ? 8'h00 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [63:0] relu_word(input logic [63:0] w);
    logic [63:0] r;
    for (int e = 0; e < 8; e++) r[e*8 +: 8] = relu8(w[e*8 +: 8]);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge and writes are logged.
  task automatic tick();
    @(posedge i_clk);
    #1;
    if (o_sram_write_en) begin
      obs_addr.push_back(o_sram_write_addr);
      obs_data.push_back(o_sram_data);
      chk("no_done_during_write", {63'b0, o_done}, 64'd0);
    end
  endtask

  task automatic start_job(input logic [7:0] st, input logic [15:0] cnt);
    i_start_addr = st;
    i_out_count  = cnt;
    i_en         = 1'b1;
    tick();
    i_en         = 1'b0;
  endtask

  task automatic beat(input logic [3:0] m, input logic [31:0] d);
    i_data_valid = m;
    i_data       = d;
    tick();
    i_data_valid = 4'h0;
  endtask

  // Runs a whole job from the beat queues, recording the element stream the model says is accepted.
  task automatic run_job(input logic [7:0] st, input logic [15:0] cnt);
    int guard;
    logic [3:0]  m;
    logic [31:0] d;
    obs_addr.delete(); obs_data.delete(); acc.delete();
    dropped = 1'b0;
    start_job(st, cnt);
    chk("ovf_clear_at_start", {63'b0, o_overflow}, 64'd0);
    guard = 0;
    while (o_ready && beat_m.size() > 0 && guard < 2000) begin
      m = beat_m.pop_front();
      d = beat_d.pop_front();
      for (int r = 0; r < 4; r++) begin
        if (m[r]) begin
          if (acc.size() < int'(cnt)) acc.push_back(relu8(d[r*8 +: 8]));
          else dropped = 1'b1;
        end
      end
      i_data_valid = m;
      i_data       = d;
      i_en         = ($urandom_range(0, 3) == 0);
      tick();
      guard++;
    end
    i_data_valid = 4'h0;
    i_en         = 1'b0;
    guard = 0;
    while (!o_done && guard < 20) begin
      tick();
      guard++;
    end
    chk("job_done", {63'b0, o_done}, 64'd1);
    beat_m.delete(); beat_d.delete();
  endtask

  initial begin
    logic [7:0]  st;
    logic [15:0] cnt;
    logic [63:0] w;
    int total, iters, nw;

    i_nrst = 1'b0; i_en = 1'b0; i_reg_clear = 1'b0;
    i_start_addr = '0; i_out_count = '0; i_data = '0; i_data_valid = '0;
    tick(); tick();
    chk("rst_ready", {63'b0, o_ready}, 64'd0);
    chk("rst_we",    {63'b0, o_sram_write_en}, 64'd0);
    chk("rst_addr",  {56'b0, o_sram_write_addr}, 64'd0);
    chk("rst_data",  o_sram_data, 64'd0);
    chk("rst_done",  {63'b0, o_done}, 64'd0);
    chk("rst_ovf",   {63'b0, o_overflow}, 64'd0);
    i_nrst = 1'b1;
    tick();
    chk("idle_done", {63'b0, o_done}, 64'd0);

    // Full word on the final beat: write next cycle, o_done the cycle after.
    start_job(8'h10, 16'd8);
    chk("a_ready", {63'b0, o_ready}, 64'd1);
    beat(4'hF, 32'h04030201);
    chk("a_no_wr_beat1", {63'b0, o_sram_write_en}, 64'd0);
    beat(4'hF, 32'h08070605);
    chk("a_wr_en",   {63'b0, o_sram_write_en}, 64'd1);
    chk("a_wr_addr", {56'b0, o_sram_write_addr}, 64'h10);
    chk("a_wr_data", o_sram_data, relu_word(64'h0807060504030201));
    chk("a_ready_low", {63'b0, o_ready}, 64'd0);
    tick();
    chk("a_done",   {63'b0, o_done}, 64'd1);
    chk("a_wr_off", {63'b0, o_sram_write_en}, 64'd0);

    // Fill 6 then a 4-lane final beat: full word first, residual of 2 the cycle after.
    start_job(8'h30, 16'd10);
    beat(4'hF, 32'h04030201);
    beat(4'h3, 32'hEEEE0605);
    chk("b_no_wr_fill6", {63'b0, o_sram_write_en}, 64'd0);
    beat(4'hF, 32'h0A090807);
    chk("b_wr1_en",   {63'b0, o_sram_write_en}, 64'd1);
    chk("b_wr1_addr", {56'b0, o_sram_write_addr}, 64'h30);
    chk("b_wr1_data", o_sram_data, 64'h0807060504030201);
    tick();
    chk("b_wr2_en",   {63'b0, o_sram_write_en}, 64'd1);
    chk("b_wr2_addr", {56'b0, o_sram_write_addr}, 64'h31);
    chk("b_wr2_data", o_sram_data, 64'h0000000000000A09);
    tick();
    chk("b_done", {63'b0, o_done}, 64'd1);

    // Register clear wins over a simultaneous start.
    start_job(8'h40, 16'd8);
    beat(4'hF, 32'h04030201);
    i_reg_clear = 1'b1; i_en = 1'b1;
    tick();
    chk("c_clear_ready", {63'b0, o_ready}, 64'd0);
    chk("c_clear_done",  {63'b0, o_done}, 64'd0);
    i_reg_clear = 1'b0; i_en = 1'b0;
    tick();
    chk("c_stays_idle", {63'b0, o_ready}, 64'd0);

    // Reset in the middle of a job.
    start_job(8'h60, 16'd32);
    beat(4'hF, 32'h04030201);
    beat(4'hF, 32'h08070605);
    beat(4'hF, 32'h0C0B0A09);
    i_nrst = 1'b0;
    tick();
    chk("d_rst_we",    {63'b0, o_sram_write_en}, 64'd0);
    chk("d_rst_addr",  {56'b0, o_sram_write_addr}, 64'd0);
    chk("d_rst_data",  o_sram_data, 64'd0);
    chk("d_rst_ready", {63'b0, o_ready}, 64'd0);
    chk("d_rst_done",  {63'b0, o_done}, 64'd0);
    i_nrst = 1'b1;
    obs_addr.delete(); obs_data.delete();
    i_data_valid = 4'hF;
    for (int k = 0; k < 5; k++) tick();
    i_data_valid = 4'h0;
    chk("d_no_writes", 64'(obs_addr.size()), 64'd0);
    chk("d_idle_ready", {63'b0, o_ready}, 64'd0);

    // Whole-job vectors: {start, count, beats, masks, lane data, writes, addrs, words, overflow}.
    tbl[0] = mk(8'h10, 16'd8,  2, 16'h00FF, {32'h0, 32'h0, 32'h08070605, 32'h04030201},
                1, {8'h00, 8'h10}, {64'h0, 64'h0807060504030201}, 1'b0);
    tbl[1] = mk(8'h20, 16'd6,  2, 16'h005F, {32'h0, 32'h0, 32'hB3A2B1A0, 32'h13121110},
                1, {8'h00, 8'h20}, {64'h0, 64'h0000A2A013121110}, 1'b0);
    tbl[2] = mk(8'h30, 16'd10, 3, 16'h0F3F, {32'h0, 32'h0A090807, 32'hEEEE0605, 32'h04030201},
                2, {8'h31, 8'h30}, {64'h0000000000000A09, 64'h0807060504030201}, 1'b0);
    tbl[3] = mk(8'h40, 16'd5,  2, 16'h00FF, {32'h0, 32'h0, 32'h08070605, 32'h04030201},
                1, {8'h00, 8'h40}, {64'h0, 64'h0000000504030201}, 1'b1);
    tbl[4] = mk(8'hFF, 16'd16, 4, 16'hFFFF, {32'h100F0E0D, 32'h0C0B0A09, 32'h08070605, 32'h04030201},
                2, {8'h00, 8'hFF}, {64'h100F0E0D0C0B0A09, 64'h0807060504030201}, 1'b0);
    tbl[5] = mk(8'h55, 16'd0,  0, 16'h0000, 128'h0, 0, 16'h0, 128'h0, 1'b0);
    tbl[6] = mk(8'h50, 16'd4,  1, 16'h000F, {32'h0, 32'h0, 32'h0, 32'h01FF7F80},
                1, {8'h00, 8'h50}, {64'h0, 64'h0000000001FF7F80}, 1'b0);
    tbl[7] = mk(8'h70, 16'd8,  4, 16'hC69A, {32'h8877EEEE, 32'hEE6655EE, 32'h44EEEE33, 32'h22EE11EE},
                1, {8'h00, 8'h70}, {64'h0, 64'h8877665544332211}, 1'b0);

    for (int i = 0; i < 8; i++) begin
      beat_m.delete(); beat_d.delete();
      for (int b = 0; b < int'(tbl[i].nbeats); b++) begin
        beat_m.push_back(tbl[i].mask[b]);
        beat_d.push_back(tbl[i].data[b]);
      end
      run_job(tbl[i].start, tbl[i].count);
      chk($sformatf("v%0d_nwr", i), 64'(obs_addr.size()), 64'(tbl[i].nwr));
      for (int k = 0; k < int'(tbl[i].nwr) && k < obs_addr.size(); k++) begin
        chk($sformatf("v%0d_addr%0d", i, k), {56'b0, obs_addr[k]}, {56'b0, tbl[i].waddr[k]});
        chk($sformatf("v%0d_data%0d", i, k), obs_data[k], relu_word(tbl[i].wdata[k]));
      end
      chk($sformatf("v%0d_ovf", i), {63'b0, o_overflow}, {63'b0, tbl[i].ovf});
    end

    // Randomized jobs against the element-stream model.
    for (int j = 0; j < 40; j++) begin
      st  = 8'($urandom);
      cnt = 16'($urandom_range(1, 40));
      beat_m.delete(); beat_d.delete();
      total = 0;
      iters = 0;
      while (total < int'(cnt) + 3 && iters < 200) begin
        logic [3:0] m;
        m = 4'($urandom_range(0, 15));
        beat_m.push_back(m);
        beat_d.push_back($urandom);
        total += int'(m[0]) + int'(m[1]) + int'(m[2]) + int'(m[3]);
        iters++;
      end
      run_job(st, cnt);
      nw = (acc.size() + 7) / 8;
      chk($sformatf("r%0d_nwr", j), 64'(obs_addr.size()), 64'(nw));
      for (int k = 0; k < nw && k < obs_addr.size(); k++) begin
        w = '0;
        for (int e = 0; e < 8; e++) begin
          if (k*8 + e < acc.size()) w[e*8 +: 8] = acc[k*8 + e];
        end
        chk($sformatf("r%0d_addr%0d", j, k), {56'b0, obs_addr[k]}, {56'b0, 8'(st + 8'(k))});
        chk($sformatf("r%0d_data%0d", j, k), obs_data[k], w);
      end
      chk($sformatf("r%0d_ovf", j), {63'b0, o_overflow}, {63'b0, dropped});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
